aq_spsram_64x58_ctrl: RTL and testbench



---
 rtl/aq_spsram_ctrl_pkg.sv | 19 +
 rtl/aq_spsram_rsp_hold.sv | 45 ++++
 rtl/aq_spsram_64x58_ctrl.sv | 139 +++++++++++++
 tb/tb_aq_spsram_64x58_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aq_spsram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aq_spsram_ctrl_pkg
// Description : Shared constants for the 64x58 single-port SRAM controller
//               (FSM encoding, default widths, idle bit-write-enable value).
// Revision    : 1.0 - initial release
// ============================================================================
package aq_spsram_ctrl_pkg;

    localparam int unsigned c_ADDR_WIDTH = 6;
    localparam int unsigned c_DATA_WIDTH = 58;

    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    localparam logic [c_DATA_WIDTH-1:0] c_WEN_ONES = '1;

endpackage
`default_nettype wire

// File: rtl/aq_spsram_rsp_hold.sv
`default_nettype none
// ============================================================================
// Module      : aq_spsram_rsp_hold
// Description : One-entry hold register for SRAM read data; captures the
//               macro output when the consumer stalls on the return cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module aq_spsram_rsp_hold
    import aq_spsram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  i_q_vld,
    input  logic [DATA_WIDTH-1:0] i_q,
    input  logic                  i_rsp_rdy,
    output logic                  o_hold_vld,
    output logic                  o_rsp_vld,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata
);

    logic                  r_hold_vld;
    logic [DATA_WIDTH-1:0] r_hold_data;

    // The requester blocks new accesses while data is pending, so a fresh
    // macro return never coincides with an occupied hold entry.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
        end else if (i_q_vld && !i_rsp_rdy) begin
            r_hold_vld  <= 1'b1;
            r_hold_data <= i_q;
        end else if (r_hold_vld && i_rsp_rdy) begin
            r_hold_vld  <= 1'b0;
        end
    end

    assign o_hold_vld  = r_hold_vld;
    assign o_rsp_vld   = r_hold_vld | i_q_vld;
    assign o_rsp_rdata = r_hold_vld ? r_hold_data : (i_q_vld ? i_q : '0);

endmodule
`default_nettype wire

// File: rtl/aq_spsram_64x58_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aq_spsram_64x58_ctrl
// Description : Requester-side controller for the LSU 64x58 single-port SRAM.
//               Optional post-reset zero sweep under AQ_SPSRAM_CTRL_INIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module aq_spsram_64x58_ctrl
    import aq_spsram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_bmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [DATA_WIDTH-1:0] c_WEN_IDLE = DATA_WIDTH'(c_WEN_ONES);

    generate
        if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
            $error("aq_spsram_64x58_ctrl: DEPTH must equal 2**ADDR_WIDTH");
        end
    endgenerate

`ifdef AQ_SPSRAM_CTRL_INIT_EN
    localparam logic [0:0] c_ST_RST = c_ST_INIT;
    logic [ADDR_WIDTH-1:0] r_init_addr;
`else
    localparam logic [0:0] c_ST_RST = c_ST_RUN;
`endif

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       r_rd_pend;
    logic       w_hold_vld;
    logic       w_acc;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state <= c_ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
`ifdef AQ_SPSRAM_CTRL_INIT_EN
        if ((r_state == c_ST_INIT) && (r_init_addr == ADDR_WIDTH'(DEPTH - 1))) begin
            w_state_nxt = c_ST_RUN;
        end
`endif
    end

`ifdef AQ_SPSRAM_CTRL_INIT_EN
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_init_addr <= '0;
        end else if (r_state == c_ST_INIT) begin
            r_init_addr <= r_init_addr + ADDR_WIDTH'(1);
        end
    end

    assign init_done = (r_state == c_ST_RUN);
`else
    assign init_done = 1'b1;
`endif

    // A stalled macro return must be captured before any new access can
    // overwrite the macro output register.
    assign req_rdy = (r_state == c_ST_RUN) && !w_hold_vld && !(r_rd_pend && !rsp_rdy);
    assign w_acc   = req_vld && req_rdy;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_acc && !req_wr;
        end
    end

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = c_WEN_IDLE;
        sram_a    = '0;
        sram_d    = '0;
`ifdef AQ_SPSRAM_CTRL_INIT_EN
        if (r_state == c_ST_INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = r_init_addr;
        end else
`endif
        if (w_acc) begin
            sram_cen = 1'b0;
            sram_a   = req_addr;
            if (req_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = ~req_bmask;
                sram_d    = req_wdata;
            end
        end
    end

    aq_spsram_rsp_hold #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_hold (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .i_q_vld        (r_rd_pend),
        .i_q            (sram_q),
        .i_rsp_rdy      (rsp_rdy),
        .o_hold_vld     (w_hold_vld),
        .o_rsp_vld      (rsp_vld),
        .o_rsp_rdata    (rsp_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_aq_spsram_64x58_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aq_spsram_64x58_ctrl
// Description : Directed self-checking bench for aq_spsram_64x58_ctrl with a
//               behavioural model of the single-port SRAM macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aq_spsram_64x58_ctrl;

    localparam logic [57:0] c_ONES = 58'h3FF_FFFF_FFFF_FFFF;
    localparam logic [57:0] c_LOW8 = 58'h000_0000_0000_00FF;
    localparam logic [57:0] c_PART = 58'h3FF_FFFF_FFFF_FF00;

    logic        forever_cpuclk = 1'b0;
    logic        cpurst_b;
    logic        req_vld, req_rdy, req_wr;
    logic [5:0]  req_addr;
    logic [57:0] req_wdata, req_bmask;
    logic        rsp_vld, rsp_rdy;
    logic [57:0] rsp_rdata;
    logic        init_done;
    logic        sram_cen, sram_gwen;
    logic [57:0] sram_wen, sram_d, sram_q;
    logic [5:0]  sram_a;

    int nvec = 0;
    int nerr = 0;

    logic [57:0] r_mem [64];

    aq_spsram_64x58_ctrl dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_bmask      (req_bmask),
        .rsp_vld        (rsp_vld),
        .rsp_rdy        (rsp_rdy),
        .rsp_rdata      (rsp_rdata),
        .init_done      (init_done),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_a         (sram_a),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    // Macro model: registered read port, per-bit active-low write mask.
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                r_mem[sram_a] <= (r_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            end else begin
                sram_q <= r_mem[sram_a];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic req(input logic vld, input logic wr, input logic [5:0] addr,
                       input logic [57:0] wd, input logic [57:0] bm);
        req_vld   = vld;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_bmask = bm;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) r_mem[i] = 58'h2AA_AAAA_AAAA_AAAA;
        sram_q    = '0;
        cpurst_b  = 1'b0;
        rsp_rdy   = 1'b1;
        req(1'b0, 1'b0, 6'd0, '0, '0);
        #10;

        // Reset state
        chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
`ifdef AQ_SPSRAM_CTRL_INIT_EN
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
`else
        chk("rst_init_done", 64'(init_done), 64'd1);
`endif

        cyc();
        cpurst_b = 1'b1;

`ifdef AQ_SPSRAM_CTRL_INIT_EN
        // Zero sweep: one write per cycle at addresses 0..63
        for (int i = 0; i < 64; i++) begin
            #1;
            chk($sformatf("init_a%0d", i), 64'(sram_a), 64'(i));
            chk($sformatf("init_cen%0d", i), 64'(sram_cen), 64'd0);
            chk($sformatf("init_gwen%0d", i), 64'(sram_gwen), 64'd0);
            chk($sformatf("init_wen%0d", i), 64'(sram_wen), 64'd0);
            chk($sformatf("init_d%0d", i), 64'(sram_d), 64'd0);
            chk($sformatf("init_rdy%0d", i), 64'(req_rdy), 64'd0);
            chk($sformatf("init_done%0d", i), 64'(init_done), 64'd0);
            cyc();
        end
`endif
        #1;
        chk("run_init_done", 64'(init_done), 64'd1);
        chk("run_req_rdy", 64'(req_rdy), 64'd1);
        chk("run_idle_cen", 64'(sram_cen), 64'd1);
        chk("run_idle_wen", 64'(sram_wen), 64'(c_ONES));

        // Read addr 17
        req(1'b1, 1'b0, 6'd17, '0, '0);
        chk("rd17_cen", 64'(sram_cen), 64'd0);
        chk("rd17_gwen", 64'(sram_gwen), 64'd1);
        chk("rd17_a", 64'(sram_a), 64'd17);
        cyc();
        req(1'b0, 1'b0, 6'd0, '0, '0);
        chk("rd17_vld", 64'(rsp_vld), 64'd1);
`ifdef AQ_SPSRAM_CTRL_INIT_EN
        chk("rd17_data", 64'(rsp_rdata), 64'd0);
`endif

        // Full write of addr 5 in the cycle the previous response is consumed
        req(1'b1, 1'b1, 6'd5, c_ONES, c_ONES);
        chk("wr5_rdy", 64'(req_rdy), 64'd1);
        chk("wr5_cen", 64'(sram_cen), 64'd0);
        chk("wr5_gwen", 64'(sram_gwen), 64'd0);
        chk("wr5_wen", 64'(sram_wen), 64'd0);
        chk("wr5_a", 64'(sram_a), 64'd5);
        chk("wr5_d", 64'(sram_d), 64'(c_ONES));
        cyc();
        req(1'b1, 1'b0, 6'd5, '0, '0);
        chk("wr5_no_rsp", 64'(rsp_vld), 64'd0);
        chk("raw5_rdy", 64'(req_rdy), 64'd1);
        cyc();
        req(1'b0, 1'b0, 6'd0, '0, '0);
        chk("raw5_vld", 64'(rsp_vld), 64'd1);
        chk("raw5_data", 64'(rsp_rdata), 64'(c_ONES));

        // Partial write: clear low byte
        req(1'b1, 1'b1, 6'd5, '0, c_LOW8);
        chk("pwr5_wen", 64'(sram_wen), 64'(c_PART));
        cyc();
        req(1'b1, 1'b0, 6'd5, '0, '0);
        cyc();
        req(1'b0, 1'b0, 6'd0, '0, '0);
        chk("prd5_data", 64'(rsp_rdata), 64'(c_PART));

        // Zero-mask write changes nothing
        req(1'b1, 1'b1, 6'd5, '0, '0);
        chk("zwr5_cen", 64'(sram_cen), 64'd0);
        chk("zwr5_gwen", 64'(sram_gwen), 64'd0);
        chk("zwr5_wen", 64'(sram_wen), 64'(c_ONES));
        cyc();
        req(1'b1, 1'b0, 6'd5, '0, '0);
        cyc();
        req(1'b0, 1'b0, 6'd0, '0, '0);
        chk("zrd5_data", 64'(rsp_rdata), 64'(c_PART));
        cyc();

        // Stalled response, with a write request pending throughout
        rsp_rdy = 1'b0;
        req(1'b1, 1'b0, 6'd5, '0, '0);
        chk("stl_acc_rdy", 64'(req_rdy), 64'd1);
        cyc();
        req(1'b1, 1'b1, 6'd9, '0, c_ONES);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stl_vld%0d", i), 64'(rsp_vld), 64'd1);
            chk($sformatf("stl_data%0d", i), 64'(rsp_rdata), 64'(c_PART));
            chk($sformatf("stl_rdy%0d", i), 64'(req_rdy), 64'd0);
            chk($sformatf("stl_cen%0d", i), 64'(sram_cen), 64'd1);
            cyc();
        end
        rsp_rdy = 1'b1;
        req(1'b0, 1'b0, 6'd0, '0, '0);
        chk("stl_rel_vld", 64'(rsp_vld), 64'd1);
        chk("stl_rel_data", 64'(rsp_rdata), 64'(c_PART));
        chk("stl_rel_rdy", 64'(req_rdy), 64'd0);
        cyc();
        chk("stl_post_vld", 64'(rsp_vld), 64'd0);
        chk("stl_post_rdy", 64'(req_rdy), 64'd1);

        // Back-to-back reads of addresses 0,1,2
        req(1'b1, 1'b1, 6'd0, 58'd1, c_ONES);
        cyc();
        req(1'b1, 1'b1, 6'd1, 58'd2, c_ONES);
        cyc();
        req(1'b1, 1'b1, 6'd2, 58'd3, c_ONES);
        cyc();
        req(1'b1, 1'b0, 6'd0, '0, '0);
        chk("b2b_rdy0", 64'(req_rdy), 64'd1);
        cyc();
        req(1'b1, 1'b0, 6'd1, '0, '0);
        chk("b2b_rdy1", 64'(req_rdy), 64'd1);
        chk("b2b_vld0", 64'(rsp_vld), 64'd1);
        chk("b2b_data0", 64'(rsp_rdata), 64'd1);
        cyc();
        req(1'b1, 1'b0, 6'd2, '0, '0);
        chk("b2b_rdy2", 64'(req_rdy), 64'd1);
        chk("b2b_vld1", 64'(rsp_vld), 64'd1);
        chk("b2b_data1", 64'(rsp_rdata), 64'd2);
        cyc();
        req(1'b0, 1'b0, 6'd0, '0, '0);
        chk("b2b_vld2", 64'(rsp_vld), 64'd1);
        chk("b2b_data2", 64'(rsp_rdata), 64'd3);
        cyc();
        chk("b2b_end_vld", 64'(rsp_vld), 64'd0);

        // Reset while a response is held
        rsp_rdy = 1'b0;
        req(1'b1, 1'b0, 6'd5, '0, '0);
        cyc();
        req(1'b0, 1'b0, 6'd0, '0, '0);
        cyc();
        chk("mrst_pre_vld", 64'(rsp_vld), 64'd1);
        chk("mrst_pre_data", 64'(rsp_rdata), 64'(c_PART));
        cpurst_b = 1'b0;
        #1;
        chk("mrst_vld", 64'(rsp_vld), 64'd0);
        chk("mrst_data", 64'(rsp_rdata), 64'd0);
`ifdef AQ_SPSRAM_CTRL_INIT_EN
        chk("mrst_rdy", 64'(req_rdy), 64'd0);
        chk("mrst_init_done", 64'(init_done), 64'd0);
        chk("mrst_a", 64'(sram_a), 64'd0);
`endif
        cyc();
        cpurst_b = 1'b1;
        #1;
        chk("mrst_rel_vld", 64'(rsp_vld), 64'd0);
`ifdef AQ_SPSRAM_CTRL_INIT_EN
        chk("mrst_sweep_a0", 64'(sram_a), 64'd0);
        chk("mrst_sweep_cen0", 64'(sram_cen), 64'd0);
        cyc();
        chk("mrst_sweep_a1", 64'(sram_a), 64'd1);
        chk("mrst_sweep_done", 64'(init_done), 64'd0);
        for (int i = 0; i < 63; i++) cyc();
`else
        chk("mrst_rel_rdy", 64'(req_rdy), 64'd1);
        cyc();
`endif
        chk("mrst_final_done", 64'(init_done), 64'd1);
        chk("mrst_final_rdy", 64'(req_rdy), 64'd1);
        chk("mrst_final_vld", 64'(rsp_vld), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
